// File: rtl/mmio_timer_pkg.sv
// Shared constants and types for the memory-mapped down-counting timer.
package mmio_timer_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_LOAD   = 8'h04;
  localparam logic [7:0] OFF_COUNT  = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;

  localparam int unsigned CTRL_EN_BIT         = 0;
  localparam int unsigned CTRL_AUTORELOAD_BIT = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT     = 2;
  localparam int unsigned CTRL_PRESCALE_LSB   = 8;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler counter: counts 0..prescale while enabled and pulses tick on the terminal value.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == prescale_i);

  // Free increment wraps at the field maximum if prescale_i drops below cnt_q.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer on the core's data bus: decode, registers, FSM, read mux.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        Sel,
  output logic        Irq
);

  timer_state_t          state_q, state_d;
  logic                  autoreload_q, autoreload_d;
  logic                  irq_en_q, irq_en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           count_q, count_d;
  logic                  expired_q, expired_d;

  logic [7:0] offset;
  logic       wr;
  logic       wr_ctrl, wr_load, wr_count, wr_status;
  logic       running;
  logic       tick;
  logic       expiry;
  logic       presc_clr;

  assign Sel     = (Addr[31:8] == BASE_ADDR[31:8]);
  assign offset  = Addr[7:0] & 8'hFC;
  assign wr      = Sel & MemWrite;
  assign running = (state_q == RUNNING);

  assign wr_ctrl   = wr && (offset == OFF_CTRL);
  assign wr_load   = wr && (offset == OFF_LOAD);
  assign wr_count  = wr && (offset == OFF_COUNT);
  assign wr_status = wr && (offset == OFF_STATUS);

  // Prescaler restarts only on the STOPPED->RUNNING edge, not on CTRL rewrites while running.
  assign presc_clr = wr_ctrl && WriteData[CTRL_EN_BIT] && !running;

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk_i     (clk),
    .rst_i     (reset),
    .en_i      (running),
    .clr_i     (presc_clr),
    .prescale_i(prescale_q),
    .tick_o    (tick)
  );

  // A COUNT write consumes the tick: no decrement and no expiry.
  assign expiry = tick && (count_q == 32'd0) && !wr_count;

  always_comb begin
    state_d      = state_q;
    autoreload_d = autoreload_q;
    irq_en_d     = irq_en_q;
    prescale_d   = prescale_q;
    load_d       = load_q;
    count_d      = count_q;
    expired_d    = expired_q;

    if (wr_ctrl) begin
      state_d      = WriteData[CTRL_EN_BIT] ? RUNNING : STOPPED;
      autoreload_d = WriteData[CTRL_AUTORELOAD_BIT];
      irq_en_d     = WriteData[CTRL_IRQ_EN_BIT];
      prescale_d   = WriteData[CTRL_PRESCALE_LSB +: PRESCALE_W];
    end else if (expiry && !autoreload_q) begin
      state_d = STOPPED;
    end

    if (wr_load) begin
      load_d = WriteData;
    end

    if (wr_count) begin
      count_d = WriteData;
    end else if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else if (autoreload_q) begin
        count_d = load_q;
      end
    end

    // Set beats a simultaneous write-one-to-clear.
    if (expiry) begin
      expired_d = 1'b1;
    end else if (wr_status && WriteData[0]) begin
      expired_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= STOPPED;
      autoreload_q <= 1'b0;
      irq_en_q     <= 1'b0;
      prescale_q   <= '0;
      load_q       <= '0;
      count_q      <= '0;
      expired_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      autoreload_q <= autoreload_d;
      irq_en_q     <= irq_en_d;
      prescale_q   <= prescale_d;
      load_q       <= load_d;
      count_q      <= count_d;
      expired_q    <= expired_d;
    end
  end

  assign Irq = expired_q & irq_en_q;

  always_comb begin
    ReadData = '0;
    if (Sel) begin
      case (offset)
        OFF_CTRL: begin
          ReadData[CTRL_EN_BIT]                       = running;
          ReadData[CTRL_AUTORELOAD_BIT]               = autoreload_q;
          ReadData[CTRL_IRQ_EN_BIT]                   = irq_en_q;
          ReadData[CTRL_PRESCALE_LSB +: PRESCALE_W]   = prescale_q;
        end
        OFF_LOAD:   ReadData = load_q;
        OFF_COUNT:  ReadData = count_q;
        OFF_STATUS: ReadData[0] = expired_q;
        default:    ReadData = '0;
      endcase
    end
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped down-counting timer that responds to the single-cycle ARM core's data-memory bus: the core issues address, write data and MemWrite; this block decodes its 256-byte window, updates its registers on the clock edge and returns ReadData combinationally in the same cycle. It sits beside the data memory. The top level muxes ReadData between memory and this block using `Sel`. `Irq` is provided for a future interrupt controller.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: window base; only bits [31:8] are compared.
- `PRESCALE_W`, default 8: prescaler field width.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `Addr` in 32: byte address (core's ALU result). Bits [1:0] are ignored.
- `WriteData` in 32: store data.
- `MemWrite` in 1: store strobe; sampled on the rising `clk` edge.
- `ReadData` out 32: register read data; combinational from `Addr` and registers.
- `Sel` out 1: `Addr[31:8] == BASE_ADDR[31:8]`; combinational.
- `Irq` out 1: `EXPIRED & IRQ_EN`; combinational from flops only.

## Operation
- Register map (offset = `Addr[7:0]`, word aligned):
  - 0x00 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN, bits[15:8] PRESCALE. Other bits read 0.
  - 0x04 LOAD: 32-bit reload value.
  - 0x08 COUNT: current count, read/write.
  - 0x0C STATUS: bit0 EXPIRED, sticky. Writing 1 clears it; writing 0 has no effect.
  - Offsets 0x10–0xFC read 0; writes to them are ignored.
- A write takes effect only when `Sel & MemWrite`. When `Sel` = 0, `ReadData` = 0.
- FSM `STOPPED`/`RUNNING`; EN reads as `state == RUNNING`.
  - STOPPED→RUNNING: a CTRL write with bit0 = 1. The prescaler is cleared to 0 on this edge.
  - RUNNING→STOPPED: a CTRL write with bit0 = 0, or a one-shot expiry.
- Prescaler: counts 0..PRESCALE while RUNNING. `tick` is asserted in the cycle where the prescaler equals PRESCALE, after which the prescaler wraps to 0. PRESCALE = 0 gives a tick every cycle.
- On `tick`:
  - If COUNT ≠ 0: COUNT ← COUNT − 1.
  - If COUNT = 0: EXPIRED ← 1. If AUTORELOAD = 1, COUNT ← LOAD. Otherwise COUNT stays 0 and the FSM goes to STOPPED.
  - Period is (LOAD+1)·(PRESCALE+1) cycles.
- Simultaneous events:
  - A COUNT write in the same cycle as `tick`: the write wins, and the tick is consumed with no decrement and no expiry.
  - A STATUS clear in the same cycle as an expiry: the set wins, so EXPIRED = 1.
  - A CTRL write while RUNNING with EN = 1 updates AUTORELOAD, IRQ_EN and PRESCALE without resetting the prescaler. If the new PRESCALE is below the current prescaler value, the prescaler counts up to the field maximum, wraps, then ticks at the new PRESCALE.
  - A LOAD write does not affect COUNT until the next reload.

## Timing
- Reset (asynchronous, any time, including mid-count): CTRL, LOAD, COUNT, STATUS and the prescaler go to 0; state goes to STOPPED.
  - Output values in reset: `Irq` = 0; `ReadData` = 0 for every address; `Sel` continues to follow `Addr`.
- Read latency is 0 cycles. Register values after a write are visible on `ReadData` from the cycle after the write edge.
- EXPIRED and `Irq` rise on the same edge as the expiring tick.

## Structure
- Package `mmio_timer_pkg` holds:
  - Register offset constants: `OFF_CTRL`, `OFF_LOAD`, `OFF_COUNT`, `OFF_STATUS`.
  - CTRL bit-position constants.
  - `timer_state_t` enum {STOPPED, RUNNING}.
- Sub-module `timer_prescaler`: the prescaler counter with clear and `tick` output.
- Everything else lives in `mmio_timer`: decode, register file, FSM and read mux.

## Test plan
- Reset and read-back:
  - Assert `reset` mid-run; all four registers then read 0 and `Irq` = 0.
  - Write LOAD = 0x1234, then read 0x04 → 0x1234.
  - Read 0x10 → 0; `Addr` = 0x0000_0004 → `Sel` = 0, `ReadData` = 0.
- One-shot:
  - Set COUNT = 3 and CTRL = 0x1 (PRESCALE = 0).
  - COUNT reads 2, 1, 0 on successive cycles. On the following edge EXPIRED = 1 and state = STOPPED; COUNT stays 0.
- Auto-reload with prescaler and IRQ:
  - LOAD = 2, COUNT = 2, CTRL = 0x0000_0107 (PRESCALE = 1).
  - `Irq` pulses set every 6 cycles. COUNT is reloaded to 2 on each expiry.
- W1C versus set:
  - Clear STATUS (write 1) in the exact cycle of an expiry → EXPIRED stays 1.
  - Clear in a later cycle → EXPIRED = 0 and `Irq` = 0.
- Write/tick collision:
  - Write COUNT = 0x50 in a tick cycle → next cycle COUNT reads 0x50, not 0x4F, and there is no expiry.
- Stop mid-run:
  - Write CTRL = 0 while COUNT = 5 → COUNT holds at 5 indefinitely.
  - Re-enable → the first decrement comes PRESCALE+1 cycles after the enabling write.
